// File: rtl/mem_stage_ctrl.sv
// MEM side of the MEM/WB pipeline latch: issues the data-cache access for the
// EX/MEM operation, holds it until dhit, and commits the writeback fields on advance.
module mem_stage_ctrl #(
  parameter int CNT_W  = 16,
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 6,
  parameter int MTR_W  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_opfunc,
  input  logic [MTR_W-1:0]  ex_MemtoReg,
  input  logic              ex_RegWEN,
  input  logic              ex_dREN,
  input  logic              ex_dWEN,
  input  logic              ex_equal,
  input  logic              ex_halt,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [WORD_W-1:0] ex_portB,
  input  logic [WORD_W-1:0] ex_npc,
  input  logic [WORD_W-1:0] ex_ALUOut,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              flush,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [OP_W-1:0]   wb_opfunc,
  output logic [MTR_W-1:0]  wb_MemtoReg,
  output logic              wb_RegWEN,
  output logic              wb_equal,
  output logic              wb_halt,
  output logic [REG_W-1:0]  wb_rd,
  output logic [WORD_W-1:0] wb_portB,
  output logic [WORD_W-1:0] wb_npc,
  output logic [WORD_W-1:0] wb_ALUOut,
  output logic [WORD_W-1:0] wb_load,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t             state;
  logic               halted;
  logic [WORD_W-1:0]  load_q;
  logic               is_mem;
  logic               req;
  logic               advance;
  logic               bubble;
  logic [WORD_W-1:0]  load_val;

  assign is_mem = ex_valid & (ex_dREN | ex_dWEN) & ~halted;
  // Gating with RST drops an in-flight request the moment reset asserts.
  assign req    = ~RST & (((state == IDLE) & is_mem) | (state == ACCESS));

  // A simultaneous read and write is treated as a store.
  assign dmemWEN   = req & ex_dWEN;
  assign dmemREN   = req & ex_dREN & ~ex_dWEN;
  assign dmemaddr  = req ? ex_ALUOut : '0;
  assign dmemstore = req ? ex_portB  : '0;
  assign mem_stall = req & ~dhit;

  assign advance  = ihit & ~mem_stall;
  assign bubble   = flush | ~ex_valid | halted;
  assign load_val = (state == HOLD) ? load_q : dmemload;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      halted      <= 1'b0;
      load_q      <= '0;
      stall_cnt   <= '0;
      wb_opfunc   <= '0;
      wb_MemtoReg <= '0;
      wb_RegWEN   <= 1'b0;
      wb_equal    <= 1'b0;
      wb_halt     <= 1'b0;
      wb_rd       <= '0;
      wb_portB    <= '0;
      wb_npc      <= '0;
      wb_ALUOut   <= '0;
      wb_load     <= '0;
    end else begin
      if (mem_stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (is_mem && !dhit) begin
            state <= ACCESS;
          end else if (is_mem && dhit && !ihit) begin
            state  <= HOLD;
            load_q <= dmemload;
          end
        end
        ACCESS: begin
          if (dhit) begin
            load_q <= dmemload;
            state  <= ihit ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (ihit)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (advance) begin
        if (bubble) begin
          wb_opfunc   <= '0;
          wb_MemtoReg <= '0;
          wb_RegWEN   <= 1'b0;
          wb_equal    <= 1'b0;
          // Once halted, wb_halt stays asserted across the trailing bubbles.
          wb_halt     <= halted;
          wb_rd       <= '0;
          wb_portB    <= '0;
          wb_npc      <= '0;
          wb_ALUOut   <= '0;
          wb_load     <= '0;
        end else begin
          wb_opfunc   <= ex_opfunc;
          wb_MemtoReg <= ex_MemtoReg;
          wb_RegWEN   <= ex_RegWEN;
          wb_equal    <= ex_equal;
          wb_halt     <= ex_halt;
          wb_rd       <= ex_rd;
          wb_portB    <= ex_portB;
          wb_npc      <= ex_npc;
          wb_ALUOut   <= ex_ALUOut;
          wb_load     <= (ex_dREN & ~ex_dWEN) ? load_val : '0;
          if (ex_halt)
            halted <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl against a per-instruction transaction model.
module tb_mem_stage_ctrl;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, ex_RegWEN, ex_dREN, ex_dWEN, ex_equal, ex_halt;
  logic [5:0]  ex_opfunc;
  logic [1:0]  ex_MemtoReg;
  logic [4:0]  ex_rd;
  logic [31:0] ex_portB, ex_npc, ex_ALUOut;
  logic        ihit, dhit, flush;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN, mem_stall;
  logic [31:0] dmemaddr, dmemstore;
  logic [5:0]  wb_opfunc;
  logic [1:0]  wb_MemtoReg;
  logic        wb_RegWEN, wb_equal, wb_halt;
  logic [4:0]  wb_rd;
  logic [31:0] wb_portB, wb_npc, wb_ALUOut, wb_load;
  logic [CW-1:0] stall_cnt;

  mem_stage_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_opfunc(ex_opfunc), .ex_MemtoReg(ex_MemtoReg),
    .ex_RegWEN(ex_RegWEN), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
    .ex_equal(ex_equal), .ex_halt(ex_halt), .ex_rd(ex_rd),
    .ex_portB(ex_portB), .ex_npc(ex_npc), .ex_ALUOut(ex_ALUOut),
    .ihit(ihit), .dhit(dhit), .dmemload(dmemload), .flush(flush),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall),
    .wb_opfunc(wb_opfunc), .wb_MemtoReg(wb_MemtoReg), .wb_RegWEN(wb_RegWEN),
    .wb_equal(wb_equal), .wb_halt(wb_halt), .wb_rd(wb_rd),
    .wb_portB(wb_portB), .wb_npc(wb_npc), .wb_ALUOut(wb_ALUOut),
    .wb_load(wb_load), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int stall_m = 0;
  bit halted_m = 0;

  logic [5:0]  e_op;
  logic [1:0]  e_mtr;
  logic        e_rwen, e_eq, e_halt;
  logic [4:0]  e_rd;
  logic [31:0] e_portb, e_npc, e_alu, e_load;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp(input logic keep_halt);
    e_op = '0; e_mtr = '0; e_rwen = 0; e_eq = 0; e_halt = keep_halt;
    e_rd = '0; e_portb = '0; e_npc = '0; e_alu = '0; e_load = '0;
  endtask

  task automatic check_wb();
    chk_eq("wb_opfunc",   64'(wb_opfunc),   64'(e_op));
    chk_eq("wb_MemtoReg", 64'(wb_MemtoReg), 64'(e_mtr));
    chk_eq("wb_RegWEN",   64'(wb_RegWEN),   64'(e_rwen));
    chk_eq("wb_equal",    64'(wb_equal),    64'(e_eq));
    chk_eq("wb_halt",     64'(wb_halt),     64'(e_halt));
    chk_eq("wb_rd",       64'(wb_rd),       64'(e_rd));
    chk_eq("wb_portB",    64'(wb_portB),    64'(e_portb));
    chk_eq("wb_npc",      64'(wb_npc),      64'(e_npc));
    chk_eq("wb_ALUOut",   64'(wb_ALUOut),   64'(e_alu));
    chk_eq("wb_load",     64'(wb_load),     64'(e_load));
  endtask

  // One instruction from presentation to commit; lat = zero-dhit cycles before dhit.
  task automatic run_instr(input bit valid, input bit dren, input bit dwen,
                           input bit halt, input bit fl, input int lat);
    bit mem, adv, done;
    int t;
    logic [31:0] ld;
    ex_valid = valid; ex_dREN = dren; ex_dWEN = dwen; ex_halt = halt; flush = fl;
    ex_opfunc = 6'($urandom); ex_MemtoReg = 2'($urandom); ex_RegWEN = 1'($urandom);
    ex_equal = 1'($urandom); ex_rd = 5'($urandom);
    ex_portB = $urandom; ex_npc = $urandom; ex_ALUOut = $urandom;
    mem = valid && (dren || dwen) && !halted_m;
    t = 0; done = 0; ld = '0;
    while (!done) begin
      dhit = mem && (t == lat);
      dmemload = $urandom;
      if (dhit) ld = dmemload;
      ihit = ((t >= lat + 3) || (!mem && t >= 3)) ? 1'b1 : 1'($urandom_range(0, 1));
      #3;
      chk_eq("dmemREN",   64'(dmemREN),   64'(mem && t <= lat && !dwen));
      chk_eq("dmemWEN",   64'(dmemWEN),   64'(mem && t <= lat && dwen));
      chk_eq("mem_stall", 64'(mem_stall), 64'(mem && t < lat));
      if (mem && t <= lat) begin
        chk_eq("dmemaddr",  64'(dmemaddr),  64'(ex_ALUOut));
        chk_eq("dmemstore", 64'(dmemstore), 64'(ex_portB));
      end
      adv = ihit && (!mem || t >= lat);
      if (mem && t < lat && stall_m < SAT) stall_m++;
      @(posedge CLK); #1;
      if (adv) begin
        if (halted_m) clear_exp(1'b1);
        else if (fl || !valid) clear_exp(1'b0);
        else begin
          e_op = ex_opfunc; e_mtr = ex_MemtoReg; e_rwen = ex_RegWEN; e_eq = ex_equal;
          e_halt = halt; e_rd = ex_rd; e_portb = ex_portB; e_npc = ex_npc;
          e_alu = ex_ALUOut; e_load = (dren && !dwen) ? ld : 32'h0;
          if (halt) halted_m = 1;
        end
        check_wb();
        done = 1;
      end else begin
        chk_eq("wb_hold_alu",  64'(wb_ALUOut), 64'(e_alu));
        chk_eq("wb_hold_load", 64'(wb_load),   64'(e_load));
      end
      t++;
    end
    chk_eq("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    $display("txn v=%0d ren=%0d wen=%0d halt=%0d flush=%0d lat=%0d cycles=%0d wb_alu=%08h wb_load=%08h stall_cnt=%0d",
             valid, dren, dwen, halt, fl, lat, t, wb_ALUOut, wb_load, stall_cnt);
    dhit = 0; ihit = 0; flush = 0;
  endtask

  initial begin
    RST = 1; ex_valid = 0; ex_dREN = 0; ex_dWEN = 0; ex_halt = 0; ex_RegWEN = 0;
    ex_equal = 0; ex_opfunc = '0; ex_MemtoReg = '0; ex_rd = '0;
    ex_portB = '0; ex_npc = '0; ex_ALUOut = '0;
    ihit = 0; dhit = 0; flush = 0; dmemload = '0;
    clear_exp(1'b0);
    repeat (2) @(posedge CLK);
    #1;
    check_wb();
    chk_eq("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk_eq("rst_dmemREN",   64'(dmemREN),   64'd0);
    RST = 0;

    // Directed: load with latency, hit-before-ihit store, flushed ALU op, plain ALU op.
    run_instr(1, 1, 0, 0, 0, 4);
    run_instr(1, 0, 1, 0, 0, 0);
    run_instr(1, 0, 0, 0, 1, 0);
    run_instr(1, 0, 0, 0, 0, 0);
    run_instr(1, 1, 1, 0, 0, 2);
    run_instr(0, 1, 0, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      run_instr(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 0,
                1'($urandom_range(0, 5) == 0), $urandom_range(0, 5));
    end

    // Reset in the middle of an outstanding load.
    ex_valid = 1; ex_dREN = 1; ex_dWEN = 0; ex_halt = 0; flush = 0;
    ex_ALUOut = 32'h40; ihit = 1; dhit = 0;
    repeat (3) @(posedge CLK);
    #3;
    chk_eq("pre_rst_dmemREN", 64'(dmemREN), 64'd1);
    RST = 1;
    #1;
    chk_eq("async_dmemREN",   64'(dmemREN),   64'd0);
    chk_eq("async_mem_stall", 64'(mem_stall), 64'd0);
    chk_eq("async_stall_cnt", 64'(stall_cnt), 64'd0);
    clear_exp(1'b0);
    check_wb();
    stall_m = 0; halted_m = 0;
    ex_valid = 0; ihit = 0;
    @(posedge CLK); #1;
    RST = 0;

    // Halt commits, then later instructions neither access memory nor clear wb_halt.
    run_instr(1, 0, 0, 1, 0, 0);
    run_instr(1, 1, 0, 0, 0, 2);
    run_instr(1, 0, 1, 0, 0, 1);
    run_instr(1, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
